// File: rtl/o9_ctrl_pkg.sv
// O9 multicycle control: shared encodings.
// States, opcodes, select codes and the strobe bundle.
package o9_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_IRLOAD = 4'd2,
    S_DECODE = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_EXEC   = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_JUMP   = 4'd13,
    S_HALT   = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       halted;
  } ctrl_t;

  function automatic logic is_done(state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) ||
           (s == S_ALUWB) || (s == S_BRANCH) ||
           (s == S_ADDIWB) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/o9_ctrl_decode.sv
// O9 multicycle control: Moore strobe table.
// Pure state -> datapath strobe/select mapping.
module o9_ctrl_decode
  import o9_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // Each state raises only its own strobes; everything else stays 0.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: ctrl_o.mem_read = 1'b1;
      S_IRLOAD: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_ONE;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD, S_MEMWB: begin
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.mem_to_reg = (state_i == S_MEMWB);
        ctrl_o.reg_write  = (state_i == S_MEMWB);
      end
      S_MEMWR: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_EXEC, S_ALUWB: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
        ctrl_o.reg_dst   = (state_i == S_ALUWB);
        ctrl_o.reg_write = (state_i == S_ALUWB);
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_HALT: ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/o9_multicycle_ctrl.sv
// O9 multicycle control FSM top level.
// State register, memory wait counter, retired count.
module o9_multicycle_ctrl
  import o9_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [5:0]         opCode,
  output logic               PCWriteCond,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count,
  output logic [3:0]         state_out
);

  localparam int WW = $clog2(MEM_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT - 1);

  state_e             state_q, state_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  ctrl_t              ctrl;

  // State, wait counter and retired count; reset parks in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; wait counter only runs while holding a memory state.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH, S_MEMRD: begin
        if (wait_q == WAIT_LAST) begin
          state_d = (state_q == S_FETCH) ? S_IRLOAD : S_MEMWB;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_IRLOAD: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opCode == OP_RTYPE): state_d = S_EXEC;
          (opCode == OP_LW),
          (opCode == OP_SW):    state_d = S_MEMADR;
          (opCode == OP_BEQ):   state_d = S_BRANCH;
          (opCode == OP_ADDI):  state_d = S_ADDIEX;
          (opCode == OP_J):     state_d = S_JUMP;
          default:              state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          (opCode == OP_LW): state_d = S_MEMRD;
          (opCode == OP_SW): state_d = S_MEMWR;
          default:           state_d = S_HALT;
        endcase
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB,
      S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d = run ? S_FETCH : S_IDLE;
        cnt_d   = cnt_q + COUNT_W'(1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are a Moore decode of the current state.
  o9_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCWrite     = ctrl.pc_write;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign halted      = ctrl.halted;
  assign instr_count = cnt_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_o9_multicycle_ctrl.sv
// Bench for o9_multicycle_ctrl: two instances
// (MEM_WAIT=1/COUNT_W=16 and MEM_WAIT=2/COUNT_W=3).
module tb_o9_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] run_v = 2'b00;
  logic [5:0] op_v [2];

  logic       pcwc0, pcw0, iord0, mr0, mw0, m2r0, irw0, asa0, rw0, rd0, h0;
  logic       pcwc1, pcw1, iord1, mr1, mw1, m2r1, irw1, asa1, rw1, rd1, h1;
  logic [1:0] pcs0, aop0, asb0, pcs1, aop1, asb1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;
  logic [3:0]  st0, st1;

  wire [16:0] strb [2];
  wire [15:0] cnt_v [2];
  wire [3:0]  st_v [2];

  int chk = 0;
  int err = 0;
  int exp_state [2];
  int exp_cnt [2];

  always #5 clk = ~clk;

  o9_multicycle_ctrl #(.MEM_WAIT(1), .COUNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .run(run_v[0]), .opCode(op_v[0]),
    .PCWriteCond(pcwc0), .PCWrite(pcw0), .IorD(iord0),
    .MemRead(mr0), .MemWrite(mw0), .MemtoReg(m2r0),
    .IRWrite(irw0), .PCSource(pcs0), .ALUOp(aop0),
    .ALUSrcB(asb0), .ALUSrcA(asa0), .RegWrite(rw0),
    .RegDst(rd0), .halted(h0), .instr_count(cnt0),
    .state_out(st0)
  );

  o9_multicycle_ctrl #(.MEM_WAIT(2), .COUNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .run(run_v[1]), .opCode(op_v[1]),
    .PCWriteCond(pcwc1), .PCWrite(pcw1), .IorD(iord1),
    .MemRead(mr1), .MemWrite(mw1), .MemtoReg(m2r1),
    .IRWrite(irw1), .PCSource(pcs1), .ALUOp(aop1),
    .ALUSrcB(asb1), .ALUSrcA(asa1), .RegWrite(rw1),
    .RegDst(rd1), .halted(h1), .instr_count(cnt1),
    .state_out(st1)
  );

  assign strb[0] = {pcwc0, pcw0, iord0, mr0, mw0, m2r0, irw0,
                    pcs0, aop0, asb0, asa0, rw0, rd0, h0};
  assign strb[1] = {pcwc1, pcw1, iord1, mr1, mw1, m2r1, irw1,
                    pcs1, aop1, asb1, asa1, rw1, rd1, h1};
  assign cnt_v[0] = cnt0;
  assign cnt_v[1] = {13'd0, cnt1};
  assign st_v[0]  = st0;
  assign st_v[1]  = st1;

  // Expected strobes for a state, read straight off the state listing.
  function automatic logic [16:0] exp_strobes(int s);
    logic pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd, h;
    logic [1:0] pcs, aop, asb;
    {pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd, h} = '0;
    {pcs, aop, asb} = '0;
    case (s)
      1: mr = 1;
      2: begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
      3: asb = 2'b11;
      4, 11: begin asa = 1; asb = 2'b10; end
      5: begin iord = 1; mr = 1; asa = 1; asb = 2'b10; end
      6: begin
        iord = 1; mr = 1; asa = 1; asb = 2'b10;
        m2r = 1; rw = 1;
      end
      7: begin iord = 1; mw = 1; asa = 1; asb = 2'b10; end
      8: begin asa = 1; aop = 2'b10; end
      9: begin asa = 1; aop = 2'b10; rd = 1; rw = 1; end
      10: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      12: begin asa = 1; asb = 2'b10; rw = 1; end
      13: begin pcw = 1; pcs = 2'b10; end
      14: h = 1;
      default: ;
    endcase
    return {pcwc, pcw, iord, mr, mw, m2r, irw,
            pcs, aop, asb, asa, rw, rd, h};
  endfunction

  function automatic bit completes(int s);
    return s == 6 || s == 7 || s == 9 || s == 10 || s == 12 || s == 13;
  endfunction

  function automatic int mw_of(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [15:0] cnt_exp(int d);
    logic [15:0] m;
    m = (d == 0) ? 16'hFFFF : 16'h0007;
    return 16'(exp_cnt[d]) & m;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    return ops[$urandom_range(0, 5)];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    run_v = 2'b00;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_state[d] = 0;
      exp_cnt[d] = 0;
    end
  endtask

  // Run one legal instruction from IDLE or a completing state.
  // mode 1 toggles run mid-instruction, mode 2 drops it in EXEC.
  task automatic exec_instr(int d, logic [5:0] op, bit run_after,
                            int mode);
    int seq[$];
    int mw;
    mw = mw_of(d);
    for (int k = 0; k < mw; k++) seq.push_back(1);
    seq.push_back(2);
    seq.push_back(3);
    case (op)
      6'h00: begin seq.push_back(8); seq.push_back(9); end
      6'h23: begin
        seq.push_back(4);
        for (int k = 0; k < mw; k++) seq.push_back(5);
        seq.push_back(6);
      end
      6'h2B: begin seq.push_back(4); seq.push_back(7); end
      6'h04: seq.push_back(10);
      6'h08: begin seq.push_back(11); seq.push_back(12); end
      default: seq.push_back(13);
    endcase
    op_v[d] = op;
    run_v[d] = 1'b1;
    if (completes(exp_state[d])) exp_cnt[d]++;
    foreach (seq[k]) begin
      @(negedge clk);
      exp_state[d] = seq[k];
      chk++;
      if (st_v[d] !== 4'(seq[k])) begin
        err++;
        $display("FAIL instr_state d%0d op %h step %0d: got %0d want %0d",
                 d, op, k, st_v[d], seq[k]);
      end
      chk++;
      if (strb[d] !== exp_strobes(seq[k])) begin
        err++;
        $display("FAIL instr_strobes d%0d op %h state %0d: got %h want %h",
                 d, op, seq[k], strb[d], exp_strobes(seq[k]));
      end
      chk++;
      if (cnt_v[d] !== cnt_exp(d)) begin
        err++;
        $display("FAIL instr_count d%0d op %h: got %0d want %0d",
                 d, op, cnt_v[d], cnt_exp(d));
      end
      if (k < seq.size() - 1) begin
        if (mode == 1) run_v[d] = 1'($urandom_range(0, 1));
        else if (mode == 2 && seq[k] == 8) run_v[d] = 1'b0;
      end
    end
    run_v[d] = run_after;
    if (!run_after) begin
      exp_cnt[d]++;
      @(negedge clk);
      exp_state[d] = 0;
      chk++;
      if (st_v[d] !== 4'd0 || strb[d] !== 17'd0) begin
        err++;
        $display("FAIL instr_idle d%0d: state %0d strobes %h want 0/0",
                 d, st_v[d], strb[d]);
      end
      chk++;
      if (cnt_v[d] !== cnt_exp(d)) begin
        err++;
        $display("FAIL instr_idle_count d%0d: got %0d want %0d",
                 d, cnt_v[d], cnt_exp(d));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk++;
      if (st_v[d] !== 4'd0 || strb[d] !== 17'd0 || cnt_v[d] !== 16'd0) begin
        err++;
        $display("FAIL reset d%0d: state %0d strobes %h count %0d want 0",
                 d, st_v[d], strb[d], cnt_v[d]);
      end
    end
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk++;
      if (st_v[d] !== 4'd0) begin
        err++;
        $display("FAIL idle_hold d%0d: got %0d want 0", d, st_v[d]);
      end
    end
  endtask

  task automatic test_each_op(int d);
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    do_reset();
    foreach (ops[i]) exec_instr(d, ops[i], 1'b0, 0);
  endtask

  task automatic test_back_to_back(int d);
    do_reset();
    for (int i = 0; i < 8; i++) exec_instr(d, pick_op(), i != 7, 0);
    chk++;
    if (cnt_v[d] !== cnt_exp(d)) begin
      err++;
      $display("FAIL back_to_back d%0d: got %0d want %0d",
               d, cnt_v[d], cnt_exp(d));
    end
  endtask

  task automatic test_run_drop(int d);
    do_reset();
    exec_instr(d, 6'h00, 1'b0, 2);
    chk++;
    if (cnt_v[d] !== 16'd1) begin
      err++;
      $display("FAIL run_drop d%0d: got %0d want 1", d, cnt_v[d]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) exec_instr(1, pick_op(), i != 8, 0);
    chk++;
    if (cnt_v[1] !== 16'd1) begin
      err++;
      $display("FAIL wrap: got %0d want 1", cnt_v[1]);
    end
  endtask

  task automatic test_halt(int d);
    int mw;
    mw = mw_of(d);
    do_reset();
    exec_instr(d, 6'h00, 1'b1, 0);
    op_v[d] = 6'h3F;
    for (int k = 0; k < mw + 2; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk++;
      if (st_v[d] !== 4'd14 || strb[d] !== 17'd1) begin
        err++;
        $display("FAIL halt d%0d cyc %0d: state %0d strobes %h want 14/1",
                 d, k, st_v[d], strb[d]);
      end
      chk++;
      if (cnt_v[d] !== 16'd1) begin
        err++;
        $display("FAIL halt_count d%0d: got %0d want 1", d, cnt_v[d]);
      end
      run_v[d] = ~run_v[d];
    end
    #1;
    reset = 1'b0;
    #1;
    chk++;
    if (st_v[d] !== 4'd0 || strb[d] !== 17'd0 || cnt_v[d] !== 16'd0) begin
      err++;
      $display("FAIL halt_reset d%0d: state %0d strobes %h count %0d",
               d, st_v[d], strb[d], cnt_v[d]);
    end
    run_v = 2'b00;
    reset = 1'b1;
    exp_state = '{0, 0};
    exp_cnt = '{0, 0};
  endtask

  task automatic test_reset_mid(int d);
    int mw;
    mw = mw_of(d);
    do_reset();
    exec_instr(d, 6'h08, 1'b1, 0);
    op_v[d] = 6'h23;
    for (int k = 0; k < mw + 4; k++) @(negedge clk);
    chk++;
    if (st_v[d] !== 4'd5) begin
      err++;
      $display("FAIL reset_mid_pre d%0d: got %0d want 5", d, st_v[d]);
    end
    #1;
    reset = 1'b0;
    #1;
    chk++;
    if (st_v[d] !== 4'd0 || strb[d] !== 17'd0 || cnt_v[d] !== 16'd0) begin
      err++;
      $display("FAIL reset_mid d%0d: state %0d strobes %h count %0d",
               d, st_v[d], strb[d], cnt_v[d]);
    end
    run_v = 2'b00;
    reset = 1'b1;
    exp_state = '{0, 0};
    exp_cnt = '{0, 0};
  endtask

  task automatic test_random(int d);
    bit ra;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ra = (i != 39) && ($urandom_range(0, 3) != 0);
      exec_instr(d, pick_op(), ra, 1);
      if (!ra) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk++;
          if (st_v[d] !== 4'd0) begin
            err++;
            $display("FAIL random_idle d%0d: got %0d want 0", d, st_v[d]);
          end
        end
      end
    end
  endtask

  initial begin
    op_v[0] = 6'h00;
    op_v[1] = 6'h00;
    exp_state = '{0, 0};
    exp_cnt = '{0, 0};
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_each_op(d);
      test_back_to_back(d);
      test_run_drop(d);
      test_halt(d);
      test_reset_mid(d);
      test_random(d);
    end
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/o9_multicycle_ctrl.md
Name: o9_multicycle_ctrl

Overview:
Main control FSM for the O9 multicycle datapath. It decodes the 6-bit opCode from the instruction register and sequences the datapath strobes (PC, memory, IR, register-file, mux selects, ALUOp) through fetch, decode, execute, memory and writeback steps. It also provides a run/idle gate, a halt on illegal opcodes, and a retired-instruction counter for debug. The datapath ALUOp input widens to 2 bits as part of this change.

Parameters:
MEM_WAIT, 1, cycles the RAM address is held before data is valid (>=1); applies to FETCH and MEMRD.
COUNT_W, 16, width of instr_count.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  1 = execute instructions; 0 = park in IDLE at the next instruction boundary
opCode  input  6  IR[31:26] from datapath
PCWriteCond  output  1  PC write if ALU zero
PCWrite  output  1  unconditional PC write
IorD  output  1  0 = PC addresses memory, 1 = ALU result
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write enable
MemtoReg  output  1  1 = memory data to register file
IRWrite  output  1  IR load
PCSource  output  2  00/01 = ALU, 10 = jump target
ALUOp  output  2  00 add, 01 sub, 10 funct-decode
ALUSrcB  output  2  00 B, 01 const 1, 10 sign-ext imm, 11 imm<<2
ALUSrcA  output  1  0 = PC, 1 = A
RegWrite  output  1  register file write
RegDst  output  1  0 = rt, 1 = rd
halted  output  1  1 while in HALT
instr_count  output  COUNT_W  retired instructions, wraps mod 2^COUNT_W
state_out  output  4  current state encoding (debug)

Behaviour:
- One clock; reset is asynchronous and active-low, with ports named clk and reset as elsewhere in the codebase.
- Reset forces state IDLE, wait counter 0 and instr_count 0. All outputs are Moore-decoded from state, so every strobe and select reads 0 and halted reads 0 immediately, including when reset hits mid-instruction.
- States (4-bit): IDLE=0, FETCH=1, IRLOAD=2, DECODE=3, MEMADR=4, MEMRD=5, MEMWB=6, MEMWR=7, EXEC=8, ALUWB=9, BRANCH=10, ADDIEX=11, ADDIWB=12, JUMP=13, HALT=14. Code 15 is illegal and goes to IDLE.
- Each state asserts only the listed signals; all others are 0.
  - IDLE: none. Goes to FETCH when run=1.
  - FETCH: MemRead. Stays MEM_WAIT cycles, tracked by the wait counter, then goes to IRLOAD.
  - IRLOAD: MemRead, IRWrite, PCWrite, ALUSrcB=01. ALUOp=00 and PCSource=00 give PC+1.
  - DECODE: ALUSrcB=11, no writes. Next state by opCode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - any other -> HALT
  - MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD for 100011, MEMWR for 101011.
  - MEMRD: IorD, MemRead, ALUSrcA=1, ALUSrcB=10. Stays MEM_WAIT cycles, then goes to MEMWB.
  - MEMWB: MEMRD signals plus MemtoReg and RegWrite (RegDst=0).
  - MEMWR: IorD, MemWrite, ALUSrcA=1, ALUSrcB=10. Exactly one cycle.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - ALUWB: EXEC signals plus RegDst and RegWrite.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10. Goes to ADDIWB.
  - ADDIWB: ADDIEX signals plus RegWrite.
  - JUMP: PCWrite, PCSource=10.
  - HALT: halted=1, no strobes. Exits only on reset; run is ignored.
- Completing states are MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP.
  - Next state is FETCH if run=1, otherwise IDLE.
  - instr_count increments by 1 on that edge.
- run is sampled only in IDLE and in completing states. Deasserting run mid-instruction never truncates the instruction.
- The wait counter clears on entry to FETCH and MEMRD; it is ceil(log2(MEM_WAIT+1)) bits wide.
- The opCode used for branching is the value present during DECODE and MEMADR (IR is stable after IRLOAD).
- instr_count wraps from all-ones to 0 without any flag.

Decomposition:
- Package o9_ctrl_pkg holds:
  - state encoding constants
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOp codes and ALUSrcB/PCSource select codes
- One natural sub-module, o9_ctrl_decode: purely combinational state -> strobe/select table.
- The top level holds the state register, wait counter and instr_count.

Test Plan:
- Release reset, run=1, opCode=000000, MEM_WAIT=1 -> states 1,2,3,8,9,1. RegWrite=RegDst=1 only in ALUWB; PCWrite=1 only in IRLOAD; instr_count=1.
- MEM_WAIT=2, opCode=100011 -> FETCH and MEMRD each last 2 cycles. MEMWB has IorD=MemRead=MemtoReg=RegWrite=1, RegDst=0. The instruction takes 8 cycles.
- opCode=101011 -> MemWrite=1 for exactly one cycle with IorD=1; RegWrite never asserts.
- opCode=000100 -> BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01, PCWrite=0. opCode=000010 -> JUMP shows PCWrite=1, PCSource=10.
- opCode=111111 -> HALT, halted=1, all strobes 0, state_out=14. Toggling run has no effect; pulsing reset low returns to IDLE with instr_count=0.
- Drop run during EXEC -> ALUWB completes and the FSM goes to IDLE, with count incremented. Assert reset during MEMRD -> all outputs 0 before the next clk edge, state_out=0.
